// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl
//   Multi-digit hex 7-segment display controller. An update is taken over a
//   valid/ready handshake, decoded one digit per cycle (MSB first) into a
//   shadow buffer, then committed in a single cycle so the display never
//   shows a half-updated value. Supports leading-zero blanking and a
//   per-digit blink mask driven by a free-running half-period counter.
//
//   Optional feature macro: SEG7_DP_EN adds an in_dp port and a decimal
//   point segment (bit 7 of each digit, active low). Without it, W = 7.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_valid       update request
//   in_ready       high only while idle
//   in_value       hex value, nibble d -> digit d (digit 0 = LSN)
//   in_lzb         1 = blank leading zeros
//   in_blink_mask  bit d = 1 -> digit d blinks
//   in_dp          (SEG7_DP_EN only) decimal point per digit, active high
//   seg_out        active-low segments, digit d at [W*d +: W], {dp,g..a}
//   upd_done       one-cycle pulse while the shadow buffer is committed

// Registered output stage for one digit: blank (all ones) or the pattern.
module seg7_out_lane #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] pat,
  input  logic         blank,
  output logic [W-1:0] seg
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg <= '1;
    else        seg <= blank ? '1 : pat;
  end
endmodule

module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  input  logic                    in_lzb,
  input  logic [NUM_DIGITS-1:0]   in_blink_mask,
`ifdef SEG7_DP_EN
  input  logic [NUM_DIGITS-1:0]   in_dp,
  output logic [8*NUM_DIGITS-1:0] seg_out,
`else
  output logic [7*NUM_DIGITS-1:0] seg_out,
`endif
  output logic                    upd_done
);

`ifdef SEG7_DP_EN
  localparam int W = 8;
`else
  localparam int W = 7;
`endif
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t                           state, state_nxt;
  logic [NUM_DIGITS-1:0][3:0]       val_q;
  logic                             lzb_q;
  logic [NUM_DIGITS-1:0]            mask_l, mask_q;
  logic [IW-1:0]                    idx;
  logic                             nz_seen;
  logic [NUM_DIGITS-1:0][W-1:0]     shadow, committed;
  logic [CW-1:0]                    cnt;
  logic                             phase;
`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0]            dp_l;
`endif

  logic [3:0]   nib;
  logic [6:0]   hex7;
  logic         lz_blank;
  logic [W-1:0] pat;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'b1000000;
      4'h1: hex_decode = 7'b1111001;
      4'h2: hex_decode = 7'b0100100;
      4'h3: hex_decode = 7'b0110000;
      4'h4: hex_decode = 7'b0011001;
      4'h5: hex_decode = 7'b0010010;
      4'h6: hex_decode = 7'b0000010;
      4'h7: hex_decode = 7'b1111000;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0011000;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b0000011;
      4'hC: hex_decode = 7'b1000110;
      4'hD: hex_decode = 7'b0100001;
      4'hE: hex_decode = 7'b0000110;
      default: hex_decode = 7'b0001110;
    endcase
  endfunction

  // Decode of the digit currently under the scan index. Leading zeros are
  // blanked until the first nonzero nibble; digit 0 always shows.
  always_comb begin
    nib      = val_q[idx];
    hex7     = hex_decode(nib);
    lz_blank = lzb_q & ~nz_seen & (nib == 4'h0) & (idx != '0);
`ifdef SEG7_DP_EN
    pat      = lz_blank ? '1 : {~dp_l[idx], hex7};
`else
    pat      = lz_blank ? '1 : hex7;
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)    state_nxt = SCAN;
      SCAN:    if (idx == '0)   state_nxt = COMMIT;
      COMMIT:                   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state == IDLE);
    upd_done = (state == COMMIT);
  end

  // Request latch, scan and commit datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q     <= '0;
      lzb_q     <= 1'b0;
      mask_l    <= '0;
      mask_q    <= '0;
      idx       <= '0;
      nz_seen   <= 1'b0;
      shadow    <= '1;
      committed <= '1;
`ifdef SEG7_DP_EN
      dp_l      <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          val_q   <= in_value;
          lzb_q   <= in_lzb;
          mask_l  <= in_blink_mask;
`ifdef SEG7_DP_EN
          dp_l    <= in_dp;
`endif
          idx     <= IDX_LAST;
          nz_seen <= 1'b0;
        end
        SCAN: begin
          shadow[idx] <= pat;
          nz_seen     <= nz_seen | (nib != 4'h0);
          idx         <= idx - 1'b1;
        end
        COMMIT: begin
          // value and blink mask switch together so blinking never
          // applies to a stale pattern
          committed <= shadow;
          mask_q    <= mask_l;
        end
        default: ;
      endcase
    end
  end

  // Free-running blink timebase, independent of updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  seg7_out_lane #(.W(W)) u_lane [NUM_DIGITS-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .pat   (committed),
    .blank (mask_q & {NUM_DIGITS{phase}}),
    .seg   (seg_out)
  );

endmodule
